// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths and grant encoding for the unified memory arbiter
package mem_arb_pkg;

  localparam int WORD_W   = 32;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } arb_grant_t;

endpackage

// File: rtl/arb_resp_reg.sv
// rtl/arb_resp_reg.sv - one-cycle valid pulse with held data/err response register
module arb_resp_reg
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              err_in,
  input  logic [WORD_W-1:0] data_in,
  output logic              valid,
  output logic              err,
  output logic [WORD_W-1:0] data
);

  // data and err hold until the next grant; valid pulses for the grant cycle only
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      err   <= 1'b0;
      data  <= '0;
    end else begin
      valid <= load;
      if (load) begin
        err  <= err_in;
        data <= data_in;
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port arbiter for shared fetch/load-store memory
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic              dm_err,
  output logic [WORD_W-1:0] dm_rdata,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              stall_if
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  logic [STREAK_W-1:0] streak;
  arb_grant_t          gnt;
  logic                dm_misaligned;
  logic [WORD_W-1:0]   dm_resp_data;
  logic                if_err_unused;
  logic [1:0]          if_offset_unused;

  assign dm_misaligned    = |dm_addr[1:0];
  assign if_offset_unused = if_addr[1:0];

  // data wins contention until fetch has lost LIMIT times in a row
  always_comb begin
    gnt = GNT_NONE;
    if (dm_req && if_req) begin
      gnt = (streak == LIMIT) ? GNT_IF : GNT_DM;
    end else if (dm_req) begin
      gnt = GNT_DM;
    end else if (if_req) begin
      gnt = GNT_IF;
    end
  end

  assign if_gnt   = (gnt == GNT_IF);
  assign dm_gnt   = (gnt == GNT_DM);
  assign stall_if = if_req & ~if_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (gnt)
      GNT_IF: mem_addr = if_addr[ADDR_W-1:2];
      GNT_DM: begin
        mem_addr  = dm_addr[ADDR_W-1:2];
        mem_we    = dm_we & ~dm_misaligned;
        mem_wdata = dm_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (if_gnt || !if_req) begin
      streak <= '0;
    end else if (dm_gnt && streak != LIMIT) begin
      streak <= streak + 1'b1;
    end
  end

  // stores and rejected accesses return zero rather than stale array data
  assign dm_resp_data = (dm_we || dm_misaligned) ? '0 : mem_rdata;

  arb_resp_reg u_if_resp (
    .clk     (clk),
    .rst     (rst),
    .load    (if_gnt),
    .err_in  (1'b0),
    .data_in (mem_rdata),
    .valid   (if_valid),
    .err     (if_err_unused),
    .data    (if_rdata)
  );

  arb_resp_reg u_dm_resp (
    .clk     (clk),
    .rst     (rst),
    .load    (dm_gnt),
    .err_in  (dm_misaligned),
    .data_in (dm_resp_data),
    .valid   (dm_valid),
    .err     (dm_err),
    .data    (dm_rdata)
  );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fill;
  logic        if_req, if_gnt, if_valid;
  logic [7:0]  if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_valid, dm_err;
  logic [7:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic        stall_if;

  logic        l_if_req, l_if_gnt, l_if_valid;
  logic [7:0]  l_if_addr;
  logic [31:0] l_if_rdata;
  logic        l_dm_req, l_dm_we, l_dm_gnt, l_dm_valid, l_dm_err;
  logic [7:0]  l_dm_addr;
  logic [31:0] l_dm_wdata, l_dm_rdata;
  logic [5:0]  l_mem_addr;
  logic        l_mem_we;
  logic [31:0] l_mem_wdata;
  logic [31:0] l_mem_rdata = 32'h0;
  logic        l_stall_if;

  logic [31:0] mem [64];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int i);
    case (i)
      0: return 32'd17;
      1: return 32'd9;
      2: return 32'd25;
      default: return (32'(i) * 32'h01010101) ^ 32'h5A;
    endcase
  endfunction

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  unified_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_valid(dm_valid), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if)
  );

  unified_mem_arbiter #(.STARVE_LIMIT(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(l_if_req), .if_addr(l_if_addr), .if_gnt(l_if_gnt), .if_valid(l_if_valid), .if_rdata(l_if_rdata),
    .dm_req(l_dm_req), .dm_we(l_dm_we), .dm_addr(l_dm_addr), .dm_wdata(l_dm_wdata), .dm_gnt(l_dm_gnt),
    .dm_valid(l_dm_valid), .dm_err(l_dm_err), .dm_rdata(l_dm_rdata),
    .mem_addr(l_mem_addr), .mem_we(l_mem_we), .mem_wdata(l_mem_wdata), .mem_rdata(l_mem_rdata),
    .stall_if(l_stall_if)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; fill = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    l_if_req = 1'b0; l_if_addr = '0;
    l_dm_req = 1'b0; l_dm_we = 1'b0; l_dm_addr = '0; l_dm_wdata = '0;
    tick;
    fill = 1'b0;
    tick;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%0b exp=0", if_valid); end
    checks++; if (dm_valid !== 1'b0) begin failures++; $display("FAIL reset_dm_valid got=%0b exp=0", dm_valid); end
    checks++; if (dm_err !== 1'b0) begin failures++; $display("FAIL reset_dm_err got=%0b exp=0", dm_err); end
    checks++; if (if_rdata !== 32'd0) begin failures++; $display("FAIL reset_if_rdata got=%0d exp=0", if_rdata); end
    checks++; if (dm_rdata !== 32'd0) begin failures++; $display("FAIL reset_dm_rdata got=%0d exp=0", dm_rdata); end
    checks++; if ({if_gnt, dm_gnt, mem_we, stall_if} !== 4'b0) begin
      failures++; $display("FAIL reset_idle_comb got=%b exp=0000", {if_gnt, dm_gnt, mem_we, stall_if});
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = 8'(i * 4);
      #1;
      checks++; if (if_gnt !== 1'b1 || stall_if !== 1'b0) begin
        failures++; $display("FAIL fetch_gnt[%0d] got gnt=%0b stall=%0b exp gnt=1 stall=0", i, if_gnt, stall_if);
      end
      checks++; if (mem_addr !== 6'(i) || mem_we !== 1'b0) begin
        failures++; $display("FAIL fetch_mem[%0d] got addr=%0d we=%0b exp addr=%0d we=0", i, mem_addr, mem_we, i);
      end
      tick;
      checks++; if (if_valid !== 1'b1 || if_rdata !== pat(i)) begin
        failures++; $display("FAIL fetch_resp[%0d] got valid=%0b data=%0d exp valid=1 data=%0d", i, if_valid, if_rdata, pat(i));
      end
    end
    if_req = 1'b0;
    tick;
    checks++; if (if_valid !== 1'b0 || if_rdata !== 32'd25) begin
      failures++; $display("FAIL fetch_hold got valid=%0b data=%0d exp valid=0 data=25", if_valid, if_rdata);
    end
  endtask

  task automatic test_starve;
    int stalls = 0;
    logic exp_d;
    if_req = 1'b1; if_addr = 8'd0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'd4;
    for (int i = 0; i < 9; i++) begin
      exp_d = (i % 3) != 2;
      #1;
      if (stall_if) stalls++;
      checks++; if (dm_gnt !== exp_d || if_gnt !== !exp_d || stall_if !== exp_d) begin
        failures++; $display("FAIL starve_gnt[%0d] got dm=%0b if=%0b stall=%0b exp dm=%0b", i, dm_gnt, if_gnt, stall_if, exp_d);
      end
      tick;
      checks++; if (dm_valid !== exp_d || if_valid !== !exp_d) begin
        failures++; $display("FAIL starve_valid[%0d] got dm=%0b if=%0b exp dm=%0b", i, dm_valid, if_valid, exp_d);
      end
      checks++; if ((exp_d && dm_rdata !== 32'd9) || (!exp_d && if_rdata !== 32'd17)) begin
        failures++; $display("FAIL starve_data[%0d] got dm=%0d if=%0d exp dm=9 if=17", i, dm_rdata, if_rdata);
      end
    end
    checks++; if (stalls != 6) begin failures++; $display("FAIL starve_stall_count got=%0d exp=6", stalls); end
    if_req = 1'b0; dm_req = 1'b0;
    tick;
  endtask

  task automatic test_store_load;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'd12; dm_wdata = 32'd34;
    #1;
    checks++; if (dm_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd3 || mem_wdata !== 32'd34) begin
      failures++; $display("FAIL store_mem got gnt=%0b we=%0b addr=%0d wdata=%0d exp 1 1 3 34", dm_gnt, mem_we, mem_addr, mem_wdata);
    end
    tick;
    checks++; if (dm_valid !== 1'b1 || dm_err !== 1'b0 || dm_rdata !== 32'd0) begin
      failures++; $display("FAIL store_resp got valid=%0b err=%0b data=%0d exp 1 0 0", dm_valid, dm_err, dm_rdata);
    end
    dm_we = 1'b0;
    tick;
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 32'd34) begin
      failures++; $display("FAIL load_after_store got valid=%0b data=%0d exp 1 34", dm_valid, dm_rdata);
    end
    checks++; if (mem[3] !== 32'd34) begin failures++; $display("FAIL store_array got=%0d exp=34", mem[3]); end
    dm_req = 1'b0;
  endtask

  task automatic test_misaligned;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'd13; dm_wdata = 32'd99;
    #1;
    checks++; if (dm_gnt !== 1'b1 || mem_we !== 1'b0) begin
      failures++; $display("FAIL misaligned_we got gnt=%0b we=%0b exp gnt=1 we=0", dm_gnt, mem_we);
    end
    tick;
    dm_req = 1'b0;
    checks++; if (dm_valid !== 1'b1 || dm_err !== 1'b1 || dm_rdata !== 32'd0) begin
      failures++; $display("FAIL misaligned_resp got valid=%0b err=%0b data=%0d exp 1 1 0", dm_valid, dm_err, dm_rdata);
    end
    checks++; if (mem[3] !== 32'd34) begin failures++; $display("FAIL misaligned_array got=%0d exp=34", mem[3]); end
    tick;
    checks++; if (dm_valid !== 1'b0) begin failures++; $display("FAIL misaligned_pulse got=%0b exp=0", dm_valid); end
  endtask

  task automatic test_reset_mid;
    logic exp_d;
    if_req = 1'b1; if_addr = 8'd0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'd0;
    tick;
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 32'd17) begin
      failures++; $display("FAIL rstmid_pre got valid=%0b data=%0d exp 1 17", dm_valid, dm_rdata);
    end
    dm_addr = 8'd4;
    #1;
    checks++; if (dm_gnt !== 1'b1) begin failures++; $display("FAIL rstmid_gnt got=%0b exp=1", dm_gnt); end
    rst = 1'b1;
    tick;
    if_req = 1'b0; dm_req = 1'b0;
    checks++; if ({dm_valid, if_valid, dm_err} !== 3'b0 || dm_rdata !== 32'd0 || if_rdata !== 32'd0) begin
      failures++; $display("FAIL rstmid_outputs got v=%b dm=%0d if=%0d exp all 0", {dm_valid, if_valid, dm_err}, dm_rdata, if_rdata);
    end
    tick;
    rst = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_d = (i != 2);
      #1;
      checks++; if (dm_gnt !== exp_d || if_gnt !== !exp_d) begin
        failures++; $display("FAIL rstmid_streak[%0d] got dm=%0b if=%0b exp dm=%0b", i, dm_gnt, if_gnt, exp_d);
      end
      tick;
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick;
  endtask

  task automatic test_limit1;
    logic exp_d;
    l_if_req = 1'b1; l_if_addr = 8'd8;
    l_dm_req = 1'b1; l_dm_we = 1'b0; l_dm_addr = 8'd16;
    for (int i = 0; i < 6; i++) begin
      exp_d = (i % 2) == 0;
      #1;
      checks++; if (l_dm_gnt !== exp_d || l_if_gnt !== !exp_d) begin
        failures++; $display("FAIL limit1_gnt[%0d] got dm=%0b if=%0b exp dm=%0b", i, l_dm_gnt, l_if_gnt, exp_d);
      end
      tick;
    end
    l_if_req = 1'b0; l_dm_req = 1'b0;
    tick;
  endtask

  task automatic test_random;
    logic [31:0] model_mem [64];
    int          lost = 0;
    logic        g_i, g_d, exp_we;
    logic        exp_if_valid, exp_dm_valid, exp_dm_err;
    logic [31:0] exp_if_rdata, exp_dm_rdata;
    bit          mis;
    rst = 1'b1; fill = 1'b1;
    if_req = 1'b0; dm_req = 1'b0;
    tick;
    rst = 1'b0; fill = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = pat(i);
    exp_if_rdata = '0; exp_dm_rdata = '0; exp_dm_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!if_req) begin
        if ($urandom_range(0, 2) != 0) begin if_req = 1'b1; if_addr = 8'($urandom); end
      end else if ($urandom_range(0, 19) == 0) begin
        if_req = 1'b0;
      end
      if (!dm_req) begin
        if ($urandom_range(0, 2) != 0) begin
          dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
          dm_addr = {6'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00};
        end
      end else if ($urandom_range(0, 19) == 0) begin
        dm_req = 1'b0;
      end
      #1;
      g_d = dm_req && !(if_req && lost == 2);
      g_i = if_req && !g_d;
      mis = dm_addr[1:0] != 2'b00;
      exp_we = g_d && dm_we && !mis;
      checks++; if (if_gnt !== g_i || dm_gnt !== g_d || stall_if !== (if_req && !g_i) || mem_we !== exp_we) begin
        failures++; $display("FAIL rand_gnt[%0d] got if=%0b dm=%0b stall=%0b we=%0b exp if=%0b dm=%0b we=%0b",
                             c, if_gnt, dm_gnt, stall_if, mem_we, g_i, g_d, exp_we);
      end
      exp_if_valid = g_i;
      exp_dm_valid = g_d;
      if (g_i) exp_if_rdata = model_mem[if_addr[7:2]];
      if (g_d) begin
        exp_dm_err   = mis;
        exp_dm_rdata = (dm_we || mis) ? 32'd0 : model_mem[dm_addr[7:2]];
        if (exp_we) model_mem[dm_addr[7:2]] = dm_wdata;
      end
      if (g_i || !if_req) lost = 0;
      else if (g_d && lost < 2) lost++;
      tick;
      checks++; if (if_valid !== exp_if_valid || if_rdata !== exp_if_rdata) begin
        failures++; $display("FAIL rand_if_resp[%0d] got v=%0b d=%h exp v=%0b d=%h", c, if_valid, if_rdata, exp_if_valid, exp_if_rdata);
      end
      checks++; if (dm_valid !== exp_dm_valid || dm_err !== exp_dm_err || dm_rdata !== exp_dm_rdata) begin
        failures++; $display("FAIL rand_dm_resp[%0d] got v=%0b e=%0b d=%h exp v=%0b e=%0b d=%h",
                             c, dm_valid, dm_err, dm_rdata, exp_dm_valid, exp_dm_err, exp_dm_rdata);
      end
      if (g_i) if_req = 1'b0;
      if (g_d) dm_req = 1'b0;
    end
    for (int i = 0; i < 64; i++) begin
      checks++; if (mem[i] !== model_mem[i]) begin
        failures++; $display("FAIL rand_array[%0d] got=%h exp=%h", i, mem[i], model_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_starve;
    test_store_load;
    test_misaligned;
    test_reset_mid;
    test_limit1;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
